immediate_encoder_writer: RTL and testbench
===========================================

Name: immediate_encoder_writer

Overview:
Write-side counterpart of the decode path's immediate extraction. It accepts (format, opcode bits, immediate) tuples over a valid/ready handshake, range-checks the immediate against the format, packs it into an 8-bit instruction word, and writes that word into instruction memory at an auto-incrementing address. It sits between the program loader (host/serial front end) and the stepper ASIP's instruction RAM, so that decode sees exactly the immediates that were requested.

Parameters:
ADDR_W, 6, instruction memory address width
BASE_ADDR, 0, first address written after start

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; opens a load session at BASE_ADDR
in_valid  input  1  tuple valid
in_ready  output  1  block accepts tuple this cycle
in_format  input  2  0: imm[2:0]→instr[4:2]; 1: imm[3:0]→instr[3:0]; 2: signed imm[4:0]→instr[4:0]; 3: no immediate
in_opbits  input  8  opcode bits; bits in immediate field positions are ignored
in_imm  input  8  immediate (two's complement for format 2)
in_last  input  1  marks final tuple of session
mem_we  output  1  instruction RAM write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  encoded instruction
done  output  1  one-cycle pulse when session ends
err_range  output  1  sticky: an out-of-range immediate was dropped
err_overflow  output  1  sticky: session exceeded memory
count  output  ADDR_W+1  instructions written this session

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err_range=0, err_overflow=0, count=0, state=IDLE. Reset is effective mid-operation; any pending write is discarded.
- States: IDLE, ACTIVE, FULL.
- IDLE: in_ready=0. start → ACTIVE, address=BASE_ADDR, count=0, both errors cleared.
- ACTIVE: in_ready=1. Accept = in_valid & in_ready.
- FULL: in_ready=0. start → ACTIVE (same as from IDLE). in_valid high in FULL sets err_overflow.
- start while ACTIVE: restart (address/count/errors cleared). The cycle carrying start accepts nothing (in_ready forced 0 that cycle).
- Encoding (mask = immediate field): fmt0 {op[7:5],imm[2:0],op[1:0]}; fmt1 {op[7:4],imm[3:0]}; fmt2 {op[7:5],imm[4:0]}; fmt3 op[7:0], imm ignored.
- Range legal: fmt0 imm≤7; fmt1 imm≤15; fmt2 imm[7:5] all equal imm[4] (−16..+15); fmt3 always legal.
- Legal accept in cycle N: mem_we=1, mem_wdata=encoded, mem_addr=current address in cycle N+1 (registered, latency 1). The address increments and count increments after the write.
- Illegal accept: no write, address/count unchanged, err_range set (sticky until start/reset). in_last still honoured.
- Full boundary: a write to address 2^ADDR_W−1 moves to FULL unless in_last is set on that tuple. The address does not wrap.
- in_last accepted: the write (if legal) occurs in N+1, done=1 in N+1, state → IDLE. in_last on the final address goes to IDLE, not FULL.
- Back-to-back accepts: one write per cycle, no bubbles.
- Outputs hold their values between writes. mem_we is a single-cycle strobe.

Test Plan:
- Reset, start, then fmt0 op=0xA3 imm=5 → cycle+1: mem_we=1, addr=0, wdata=0xB7, count=1.
- Back-to-back fmt1 op=0x50 imm=0xC, then fmt2 op=0xE0 imm=0xF3 (−13) → wdata 0x5C@addr0, 0xF3@addr1 on consecutive cycles.
- fmt2 imm=0x10 (+16) → no mem_we, err_range=1, next legal tuple is written to the same address.
- ADDR_W=2: 4 tuples without in_last → 4 writes to addresses 0–3, in_ready=0 afterwards, 5th in_valid sets err_overflow. Then start → ACTIVE at addr 0 with errors cleared.
- fmt3 op=0x81 imm=0xFF with in_last → wdata=0x81, done pulses the same cycle as mem_we, state IDLE, in_ready=0.
- reset_n asserted low mid-session with in_valid high → outputs return to reset values immediately and no write occurs.

Source files
------------

// File: rtl/immediate_encoder_writer.sv
// rtl/immediate_encoder_writer.sv - range-checks and packs immediates into instruction words written to instruction RAM
module immediate_encoder_writer #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_format,
    input  logic [7:0]        in_opbits,
    input  logic [7:0]        in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err_range,
    output logic              err_overflow,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              legal;
    logic [7:0]        encoded;

    // A start pulse always wins, so the cycle carrying it never accepts a tuple.
    assign in_ready = (state == ACTIVE) && !start;
    assign accept   = in_valid && in_ready;

    // Pack the immediate into its field and decide whether it fits the format.
    always_comb begin
        encoded = in_opbits;
        legal   = 1'b1;
        unique case (in_format)
            2'd0: begin
                encoded = {in_opbits[7:5], in_imm[2:0], in_opbits[1:0]};
                legal   = (in_imm[7:3] == 5'd0);
            end
            2'd1: begin
                encoded = {in_opbits[7:4], in_imm[3:0]};
                legal   = (in_imm[7:4] == 4'd0);
            end
            2'd2: begin
                encoded = {in_opbits[7:5], in_imm[4:0]};
                legal   = (in_imm[7:5] == {3{in_imm[4]}});
            end
            default: begin
                encoded = in_opbits;
                legal   = 1'b1;
            end
        endcase
    end

    // Session control, write port and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= BASE;
            mem_we       <= 1'b0;
            mem_addr     <= BASE;
            mem_wdata    <= 8'd0;
            done         <= 1'b0;
            err_range    <= 1'b0;
            err_overflow <= 1'b0;
            count        <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (start) begin
                state        <= ACTIVE;
                addr         <= BASE;
                count        <= '0;
                err_range    <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                case (state)
                    ACTIVE: begin
                        if (accept) begin
                            if (legal) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= encoded;
                                count     <= count + 1'b1;
                                // The address never wraps: the top slot parks the session in FULL.
                                if (!in_last) begin
                                    if (addr == LAST_ADDR) begin
                                        state <= FULL;
                                    end else begin
                                        addr <= addr + 1'b1;
                                    end
                                end
                            end else begin
                                err_range <= 1'b1;
                            end
                            if (in_last) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    FULL: begin
                        if (in_valid) begin
                            err_overflow <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_immediate_encoder_writer.sv
// tb/tb_immediate_encoder_writer.sv - randomized self-checking bench for immediate_encoder_writer
module tb_immediate_encoder_writer;

    localparam int AW   = 3;
    localparam int BASE = 2;
    localparam int TOP  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_format;
    logic [7:0]    in_opbits;
    logic [7:0]    in_imm;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          done;
    logic          err_range;
    logic          err_overflow;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    // model: session mode 0 = idle, 1 = loading, 2 = memory exhausted
    int m_mode;
    int m_next;
    int m_cnt;
    int m_erng;
    int m_eovf;
    int e_we;
    int e_done;
    int e_addr;
    int e_wdata;

    immediate_encoder_writer #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opbits(in_opbits), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
        .err_range(err_range), .err_overflow(err_overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int model_enc(int fmt, int op, int imm);
        case (fmt)
            0:       return (op & 'hE3) | ((imm & 7) << 2);
            1:       return (op & 'hF0) | (imm & 'hF);
            2:       return (op & 'hE0) | (imm & 'h1F);
            default: return op;
        endcase
    endfunction

    function automatic bit model_legal(int fmt, int imm);
        int s;
        s = (imm > 127) ? imm - 256 : imm;
        case (fmt)
            0:       return imm <= 7;
            1:       return imm <= 15;
            2:       return (s >= -16) && (s <= 15);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_next  = BASE;
        m_cnt   = 0;
        m_erng  = 0;
        m_eovf  = 0;
        e_we    = 0;
        e_done  = 0;
        e_addr  = BASE;
        e_wdata = 0;
    endtask

    task automatic model_step(input bit st, input bit v, input int fmt, input int op, input int imm, input bit last);
        e_we   = 0;
        e_done = 0;
        if (st) begin
            m_mode = 1;
            m_next = BASE;
            m_cnt  = 0;
            m_erng = 0;
            m_eovf = 0;
        end else if (m_mode == 1 && v) begin
            if (model_legal(fmt, imm)) begin
                e_we    = 1;
                e_addr  = m_next;
                e_wdata = model_enc(fmt, op, imm);
                m_cnt++;
                if (!last) begin
                    if (m_next == TOP) m_mode = 2;
                    else m_next++;
                end
            end else begin
                m_erng = 1;
            end
            if (last) begin
                e_done = 1;
                m_mode = 0;
            end
        end else if (m_mode == 2 && v) begin
            m_eovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("mem_we", mem_we, e_we);
        chk("done", done, e_done);
        chk("err_range", err_range, m_erng);
        chk("err_overflow", err_overflow, m_eovf);
        chk("count", count, m_cnt);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
    endtask

    // one clock cycle: drive at the falling edge, check ready, advance model, check registered outputs
    task automatic cyc(input bit st, input bit v, input int fmt, input int op, input int imm, input bit last);
        start     = st;
        in_valid  = v;
        in_format = fmt[1:0];
        in_opbits = op[7:0];
        in_imm    = imm[7:0];
        in_last   = last;
        #1;
        chk("in_ready", in_ready, (m_mode == 1 && !st) ? 1 : 0);
        model_step(st, v, fmt, op, imm, last);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_format = 2'd0;
        in_opbits = 8'd0;
        in_imm    = 8'd0;
        in_last   = 1'b0;
        model_reset();

        chk("model_enc0", model_enc(0, 'hA3, 5), 'hB7);
        chk("model_enc2", model_enc(2, 'hE0, 'hF3), 'hF3);
        chk("model_legal2", model_legal(2, 'h10), 0);

        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_addr_lit", mem_addr, BASE);
        chk("rst_ready_lit", in_ready, 0);
        reset_n = 1'b1;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 'hA3, 5, 0);
        chk("fmt0_we_lit", mem_we, 1);
        chk("fmt0_addr_lit", mem_addr, BASE);
        chk("fmt0_wdata_lit", mem_wdata, 'hB7);
        chk("fmt0_count_lit", count, 1);
        cyc(0, 1, 1, 'h50, 'hC, 0);
        chk("fmt1_wdata_lit", mem_wdata, 'h5C);
        chk("fmt1_addr_lit", mem_addr, BASE + 1);
        cyc(0, 1, 2, 'hE0, 'hF3, 0);
        chk("fmt2_wdata_lit", mem_wdata, 'hF3);
        chk("fmt2_we_lit", mem_we, 1);
        cyc(0, 1, 2, 'hE0, 'h10, 0);
        chk("range_we_lit", mem_we, 0);
        chk("range_err_lit", err_range, 1);
        cyc(0, 1, 3, 'h81, 'hFF, 0);
        chk("after_range_addr_lit", mem_addr, BASE + 3);
        for (int a = BASE + 4; a <= TOP; a++) cyc(0, 1, 1, 'h30, a, 0);
        chk("top_addr_lit", mem_addr, TOP);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_ready_lit", in_ready, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("overflow_lit", err_overflow, 1);
        chk("overflow_we_lit", mem_we, 0);
        cyc(1, 1, 0, 0, 1, 0);
        chk("restart_ovf_lit", err_overflow, 0);
        chk("restart_count_lit", count, 0);
        cyc(0, 1, 3, 'h81, 'hFF, 1);
        chk("last_wdata_lit", mem_wdata, 'h81);
        chk("last_done_lit", done, 1);
        chk("last_addr_lit", mem_addr, BASE);
        cyc(0, 1, 0, 0, 0, 0);
        chk("idle_ready_lit", in_ready, 0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            int imm;
            r = $urandom_range(0, 3);
            case (r)
                0:       imm = $urandom_range(0, 255);
                1:       imm = $urandom_range(0, 17);
                default: imm = (256 - $urandom_range(0, 18)) & 255;
            endcase
            cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75,
                $urandom_range(0, 3), $urandom_range(0, 255), imm,
                $urandom_range(0, 99) < 8);
        end

        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 'h50, 'hA, 0);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_format = 2'd1;
        in_opbits = 8'h50;
        in_imm    = 8'd3;
        in_last   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("midrst_ready_lit", in_ready, 0);
        chk("midrst_we_lit", mem_we, 0);
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        cyc(0, 1, 1, 'h50, 3, 0);
        chk("postrst_count_lit", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
